pwm_ramp_controller: RTL and testbench



---
 rtl/pwm_ramp_controller.sv | 174 +++++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// PWM register file and duty-cycle ramp sequencer.
// SPI byte writes load the enable, duty, target and divider registers.
// A ramp engine steps the duty toward the target, either once or back and forth.
// An SPI write to the duty register always takes ownership from the ramp engine.
module pwm_ramp_controller #(
  parameter int TICK_DIV = 1000,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       ramp_busy,
  output logic       ramp_done
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [8:0]      STEP9    = 9'(STEP);

  localparam logic [6:0] ADDR_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY   = 7'h04;
  localparam logic [6:0] ADDR_TARGET = 7'h05;
  localparam logic [6:0] ADDR_DIV    = 7'h06;
  localparam logic [6:0] ADDR_CTRL   = 7'h07;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    target;
  logic [7:0]    div;
  logic [7:0]    origin;
  logic          mode;
  logic [PW-1:0] prescaler;
  logic [7:0]    div_cnt;

  logic       wr_duty;
  logic       wr_target;
  logic       wr_div;
  logic       wr_ctrl;
  logic       start;
  logic       stop;
  logic       do_start;
  logic       start_done;
  logic       in_ramp;
  logic       abort;
  logic       ramp_active;
  logic       tick_wrap;
  logic       take_step;
  logic       reached;
  logic       finish_oneshot;
  logic       bounce;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] step_duty;

  // Decode the write strobe and the control decisions that depend on it
  always_comb begin
    wr_duty        = wr_valid && (wr_addr == ADDR_DUTY);
    wr_target      = wr_valid && (wr_addr == ADDR_TARGET);
    wr_div         = wr_valid && (wr_addr == ADDR_DIV);
    wr_ctrl        = wr_valid && (wr_addr == ADDR_CTRL);
    start          = wr_ctrl && wr_data[0];
    stop           = wr_ctrl && wr_data[2];
    in_ramp        = (state == RAMP);
    do_start       = start && !stop;
    start_done     = do_start && (target == pwm_duty_cycle);
    abort          = in_ramp && (stop || wr_duty);
    ramp_active    = in_ramp && !stop && !wr_duty && !start;
    tick_wrap      = (prescaler == PRE_LAST);
    take_step      = ramp_active && tick_wrap && (div_cnt == div);
    reached        = (step_duty == target);
    finish_oneshot = take_step && reached && !mode;
    bounce         = take_step && reached && mode;
  end

  // Next duty value one step toward the target, clamped so it never overshoots or wraps
  always_comb begin
    sum9      = {1'b0, pwm_duty_cycle} + STEP9;
    diff9     = {1'b0, pwm_duty_cycle} - STEP9;
    step_duty = target;
    if (pwm_duty_cycle < target) begin
      if (sum9 < {1'b0, target}) step_duty = sum9[7:0];
    end else if (pwm_duty_cycle > target) begin
      if (!diff9[8] && (diff9[7:0] > target)) step_duty = diff9[7:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: aborts beat restarts, restarts beat normal completion
  always_comb begin
    state_next = state;
    if (abort)               state_next = IDLE;
    else if (do_start)       state_next = start_done ? IDLE : RAMP;
    else if (finish_oneshot) state_next = IDLE;
  end

  // FSM outputs
  always_comb begin
    ramp_busy = (state == RAMP);
  end

  // Enable registers, touched only by their own addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
    end else if (wr_valid) begin
      if (wr_addr == ADDR_OUT_LO) en_reg_out_7_0  <= wr_data;
      if (wr_addr == ADDR_OUT_HI) en_reg_out_15_8 <= wr_data;
      if (wr_addr == ADDR_PWM_LO) en_reg_pwm_7_0  <= wr_data;
      if (wr_addr == ADDR_PWM_HI) en_reg_pwm_15_8 <= wr_data;
    end
  end

  // Duty, target, origin and mode: SPI writes take priority over ramp updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_duty_cycle <= 8'h00;
      target         <= 8'h00;
      div            <= 8'h00;
      origin         <= 8'h00;
      mode           <= 1'b0;
    end else begin
      if (wr_duty)        pwm_duty_cycle <= wr_data;
      else if (take_step) pwm_duty_cycle <= step_duty;
      if (wr_target)      target <= wr_data;
      else if (bounce)    target <= origin;
      if (wr_div)         div <= wr_data;
      if (do_start)       origin <= pwm_duty_cycle;
      else if (bounce)    origin <= step_duty;
      if (do_start)       mode <= wr_data[1];
    end
  end

  // Prescaler and step divider; both idle at zero outside a ramp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      div_cnt   <= 8'h00;
    end else if (do_start || !in_ramp) begin
      prescaler <= '0;
      div_cnt   <= 8'h00;
    end else begin
      prescaler <= tick_wrap ? '0 : prescaler + 1'b1;
      if (wr_div)                 div_cnt <= 8'h00;
      else if (tick_wrap)         div_cnt <= (div_cnt == div) ? 8'h00 : div_cnt + 8'h01;
    end
  end

  // One-cycle completion pulse for a one-shot ramp or an already-satisfied start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramp_done <= 1'b0;
    else        ramp_done <= start_done || finish_oneshot;
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed testbench for pwm_ramp_controller with TICK_DIV=4, STEP=16.
module tb_pwm_ramp_controller;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       ramp_busy;
  logic       ramp_done;

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  int snap;
  logic seen_f5 = 1'b0;

  pwm_ramp_controller #(.TICK_DIV(4), .STEP(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .ramp_busy(ramp_busy),
    .ramp_done(ramp_done)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses and watch for a forbidden duty value shortly after each edge
  always @(posedge clk) begin
    #2;
    if (ramp_done) done_count++;
    if (pwm_duty_cycle == 8'hF5) seen_f5 = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one write starting at a negedge; returns at the following negedge
  task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_addr  = 7'h00;
    wr_data  = 8'h00;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 7'h00;
    wr_data  = 8'h00;
    waitCycles(2);

    checkOutput("rst_out_lo", en_reg_out_7_0, 8'h00);
    checkOutput("rst_out_hi", en_reg_out_15_8, 8'h00);
    checkOutput("rst_pwm_lo", en_reg_pwm_7_0, 8'h00);
    checkOutput("rst_pwm_hi", en_reg_pwm_15_8, 8'h00);
    checkOutput("rst_duty", pwm_duty_cycle, 8'h00);
    checkOutput("rst_busy", {7'b0, ramp_busy}, 8'h00);
    checkOutput("rst_done", {7'b0, ramp_done}, 8'h00);
    rst_n = 1'b1;
    waitCycles(1);

    // Register writes and an ignored address
    applyStimulus(7'h00, 8'hF0);
    applyStimulus(7'h01, 8'h0F);
    applyStimulus(7'h02, 8'hAA);
    applyStimulus(7'h03, 8'h55);
    applyStimulus(7'h04, 8'h80);
    applyStimulus(7'h09, 8'hFF);
    checkOutput("wr_out_lo", en_reg_out_7_0, 8'hF0);
    checkOutput("wr_out_hi", en_reg_out_15_8, 8'h0F);
    checkOutput("wr_pwm_lo", en_reg_pwm_7_0, 8'hAA);
    checkOutput("wr_pwm_hi", en_reg_pwm_15_8, 8'h55);
    checkOutput("wr_duty", pwm_duty_cycle, 8'h80);
    checkOutput("wr_09_busy", {7'b0, ramp_busy}, 8'h00);
    checkOutput("wr_09_done", {7'b0, ramp_done}, 8'h00);

    // One-shot ramp up 0x00 -> 0x30
    applyStimulus(7'h04, 8'h00);
    applyStimulus(7'h05, 8'h30);
    applyStimulus(7'h06, 8'h00);
    snap = done_count;
    applyStimulus(7'h07, 8'h01);
    checkOutput("up_busy0", {7'b0, ramp_busy}, 8'h01);
    waitCycles(3);
    checkOutput("up_pre_step", pwm_duty_cycle, 8'h00);
    waitCycles(1);
    checkOutput("up_step1", pwm_duty_cycle, 8'h10);
    waitCycles(4);
    checkOutput("up_step2", pwm_duty_cycle, 8'h20);
    checkOutput("up_busy2", {7'b0, ramp_busy}, 8'h01);
    waitCycles(4);
    checkOutput("up_step3", pwm_duty_cycle, 8'h30);
    checkOutput("up_busy_fall", {7'b0, ramp_busy}, 8'h00);
    checkOutput("up_done_pulse", {7'b0, ramp_done}, 8'h01);
    waitCycles(1);
    checkOutput("up_done_low", {7'b0, ramp_done}, 8'h00);
    checkOutput("up_done_count", 8'(done_count - snap), 8'h01);

    // Saturation at 0xFF, then ramp down to 0x05 without wrapping
    applyStimulus(7'h04, 8'hF8);
    applyStimulus(7'h05, 8'hFF);
    snap = done_count;
    applyStimulus(7'h07, 8'h01);
    waitCycles(4);
    checkOutput("sat_duty", pwm_duty_cycle, 8'hFF);
    checkOutput("sat_busy", {7'b0, ramp_busy}, 8'h00);
    checkOutput("sat_done", {7'b0, ramp_done}, 8'h01);
    applyStimulus(7'h05, 8'h05);
    seen_f5 = 1'b0;
    applyStimulus(7'h07, 8'h01);
    waitCycles(4);
    checkOutput("down_step1", pwm_duty_cycle, 8'hEF);
    waitCycles(56);
    checkOutput("down_step15", pwm_duty_cycle, 8'h0F);
    checkOutput("down_busy15", {7'b0, ramp_busy}, 8'h01);
    waitCycles(4);
    checkOutput("down_final", pwm_duty_cycle, 8'h05);
    checkOutput("down_busy", {7'b0, ramp_busy}, 8'h00);
    checkOutput("down_no_f5", {7'b0, seen_f5}, 8'h00);
    checkOutput("down_done_count", 8'(done_count - snap), 8'h02);

    // Triangle mode 0x10 <-> 0x30, then STOP
    applyStimulus(7'h04, 8'h10);
    applyStimulus(7'h05, 8'h30);
    snap = done_count;
    applyStimulus(7'h07, 8'h03);
    waitCycles(8);
    checkOutput("tri_top", pwm_duty_cycle, 8'h30);
    checkOutput("tri_busy_top", {7'b0, ramp_busy}, 8'h01);
    waitCycles(4);
    checkOutput("tri_down", pwm_duty_cycle, 8'h20);
    waitCycles(4);
    checkOutput("tri_bottom", pwm_duty_cycle, 8'h10);
    waitCycles(4);
    checkOutput("tri_up_again", pwm_duty_cycle, 8'h20);
    applyStimulus(7'h07, 8'h04);
    checkOutput("tri_stop_busy", {7'b0, ramp_busy}, 8'h00);
    waitCycles(8);
    checkOutput("tri_stop_hold", pwm_duty_cycle, 8'h20);
    checkOutput("tri_no_done", 8'(done_count - snap), 8'h00);

    // SPI duty write on a step cycle aborts the ramp
    applyStimulus(7'h04, 8'h00);
    applyStimulus(7'h05, 8'h40);
    snap = done_count;
    applyStimulus(7'h07, 8'h01);
    waitCycles(7);
    checkOutput("ovr_pre", pwm_duty_cycle, 8'h10);
    applyStimulus(7'h04, 8'h77);
    checkOutput("ovr_duty", pwm_duty_cycle, 8'h77);
    checkOutput("ovr_busy", {7'b0, ramp_busy}, 8'h00);
    waitCycles(8);
    checkOutput("ovr_hold", pwm_duty_cycle, 8'h77);
    checkOutput("ovr_no_done", 8'(done_count - snap), 8'h00);

    // Asynchronous reset in the middle of a ramp
    applyStimulus(7'h05, 8'h00);
    applyStimulus(7'h07, 8'h01);
    waitCycles(2);
    checkOutput("mid_busy", {7'b0, ramp_busy}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_duty", pwm_duty_cycle, 8'h00);
    checkOutput("arst_busy", {7'b0, ramp_busy}, 8'h00);
    checkOutput("arst_out_lo", en_reg_out_7_0, 8'h00);
    checkOutput("arst_pwm_hi", en_reg_pwm_15_8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("post_rst_duty", pwm_duty_cycle, 8'h00);
    checkOutput("post_rst_busy", {7'b0, ramp_busy}, 8'h00);

    // START with target already equal to duty after reset: immediate done
    applyStimulus(7'h07, 8'h01);
    checkOutput("eq_done", {7'b0, ramp_done}, 8'h01);
    checkOutput("eq_busy", {7'b0, ramp_busy}, 8'h00);
    waitCycles(1);
    checkOutput("eq_done_low", {7'b0, ramp_done}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
